mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/rr_arb2.sv | 42 ++++
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared definitions for the two-requester memory arbiter:
//   - state_t     : arbiter FSM states (IDLE, ACCESS, RESP)
//   - FETCH / LSU : requester index constants (bit positions in req_valid etc.)
//   - DEF_*       : default geometry (memory depth, address and data widths)
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int FETCH = 0;
    localparam int LSU   = 1;

    localparam int DEF_DEPTH = 32;
    localparam int DEF_AW    = 32;
    localparam int DEF_DW    = 32;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundles the requester handshake, response and memory-side signals of the
// arbiter.
//   Requester -> arbiter : req_valid[1:0], req_we[1:0], req_addr0/1, req_wdata0/1
//   Arbiter -> requester : req_ready[1:0], rsp_valid[1:0], rsp_rdata, rsp_err
//   Arbiter -> memory    : mem_en, mem_we, mem_addr, mem_wdata
//   Memory -> arbiter    : mem_rdata (synchronous read, 1-cycle latency)
// Modports: slave = arbiter view, master = requester/memory environment view.
interface mem_arbiter_if #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 32
);
    localparam int MAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [1:0]     req_valid;
    logic [1:0]     req_we;
    logic [AW-1:0]  req_addr0;
    logic [AW-1:0]  req_addr1;
    logic [DW-1:0]  req_wdata0;
    logic [DW-1:0]  req_wdata1;
    logic [1:0]     req_ready;
    logic [1:0]     rsp_valid;
    logic [DW-1:0]  rsp_rdata;
    logic           rsp_err;
    logic           mem_en;
    logic           mem_we;
    logic [MAW-1:0] mem_addr;
    logic [DW-1:0]  mem_wdata;
    logic [DW-1:0]  mem_rdata;

    modport slave (
        input  req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
        input  mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
        output mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/rr_arb2.sv
// rr_arb2
// Two-way grant selection, purely combinational.
//   req[1:0]   : pending requests (bit 0 fetch, bit 1 load/store)
//   last_grant : index of the most recently granted requester
//   gnt[1:0]   : one-hot grant, zero when no request is pending
// Build option MEM_ARB_RR_EN: when defined, a tie goes to the requester that
// was not granted last; otherwise fetch always wins a tie.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

`ifdef MEM_ARB_RR_EN
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            // Tie: favour whichever side did not win the previous accept.
            2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end
`else
    // Fixed priority has no use for history; sink it so the port stays uniform.
    logic w_unused_last_grant;
    assign w_unused_last_grant = last_grant;

    always_comb begin
        gnt = 2'b00;
        if (req[FETCH]) begin
            gnt[FETCH] = 1'b1;
        end else if (req[LSU]) begin
            gnt[LSU] = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one synchronous-read memory between a fetch requester (index 0) and
// a load/store requester (index 1). Each access takes three cycles:
//   T   IDLE   : one request granted (req_ready one-hot), its fields latched
//   T+1 ACCESS : memory strobed if the address is in range
//   T+2 RESP   : rsp_valid pulsed for the granted requester with data/error
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : mem_arbiter_if.slave (requester handshake + memory port)
// Build option MEM_ARB_RR_EN: round-robin tie-break using a last-grant
// register (reset to 1 so fetch wins the first tie); fixed priority otherwise.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    localparam int MAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t        r_state;
    state_t        w_state_next;
    logic          r_idx;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;

    logic [1:0]    w_gnt;
    logic          w_gnt_idx;
    logic          w_accept;
    logic          w_in_range;
    logic          w_last_grant;

`ifdef MEM_ARB_RR_EN
    logic          r_last_grant;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_last_grant <= w_gnt_idx;
        end
    end

    assign w_last_grant = r_last_grant;
`else
    assign w_last_grant = 1'b1;
`endif

    rr_arb2 u_arb (
        .req        (bus.req_valid),
        .last_grant (w_last_grant),
        .gnt        (w_gnt)
    );

    assign w_gnt_idx = w_gnt[LSU];
    assign w_accept  = (r_state == IDLE) && rst_n && (w_gnt != 2'b00);
    // Full-width compare so stray upper address bits are flagged, not aliased.
    assign w_in_range = (r_addr < AW'(DEPTH));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_idx   <= w_gnt_idx;
                r_we    <= bus.req_we[w_gnt_idx];
                r_addr  <= w_gnt_idx ? bus.req_addr1  : bus.req_addr0;
                r_wdata <= w_gnt_idx ? bus.req_wdata1 : bus.req_wdata0;
            end
        end
    end

    // Outputs are decoded from state and gated by rst_n so that every output
    // reads zero during a reset cycle, regardless of where the FSM was.
    always_comb begin
        w_state_next  = r_state;
        bus.req_ready = 2'b00;
        bus.rsp_valid = 2'b00;
        bus.rsp_rdata = '0;
        bus.rsp_err   = 1'b0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;

        case (r_state)
            IDLE: begin
                if (rst_n) begin
                    bus.req_ready = w_gnt;
                end
                if (w_accept) begin
                    w_state_next = ACCESS;
                end
            end

            ACCESS: begin
                w_state_next = RESP;
                if (rst_n && w_in_range) begin
                    bus.mem_en    = 1'b1;
                    bus.mem_we    = r_we;
                    bus.mem_addr  = r_addr[MAW-1:0];
                    bus.mem_wdata = r_wdata;
                end
            end

            RESP: begin
                w_state_next = IDLE;
                if (rst_n) begin
                    bus.rsp_valid = r_idx ? 2'b10 : 2'b01;
                    bus.rsp_err   = !w_in_range;
                    // Memory data is only meaningful for an in-range read.
                    if (!r_we && w_in_range) begin
                        bus.rsp_rdata = bus.mem_rdata;
                    end
                end
            end

            default: w_state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter with a small synchronous-read memory model.
// Contention expectations follow MEM_ARB_RR_EN when it is defined.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    mem_arbiter_if #(.AW(32), .DW(32), .DEPTH(32)) bus ();

    mem_arbiter #(.DEPTH(32), .AW(32), .DW(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Memory model: preloaded while mem_init is high, 1-cycle read latency.
    logic        mem_init;
    logic [31:0] mem_model [0:31];
    logic [31:0] mem_rdata_q;

    always @(posedge clk) begin
        if (mem_init) begin
            mem_model[1]  <= 32'h0000_0011;
            mem_model[2]  <= 32'h0000_0022;
            mem_model[3]  <= 32'h0000_0033;
            mem_model[5]  <= 32'h0000_00A5;
            mem_model[31] <= 32'h0000_0000;
        end else if (bus.mem_en) begin
            if (bus.mem_we) mem_model[bus.mem_addr] <= bus.mem_wdata;
            else            mem_rdata_q <= mem_model[bus.mem_addr];
        end
    end
    assign bus.mem_rdata = mem_rdata_q;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, want summary before %0t", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_init = 1'b1;
        bus.req_valid = 2'b11; bus.req_we = 2'b00;
        bus.req_addr0 = '0; bus.req_addr1 = '0;
        bus.req_wdata0 = '0; bus.req_wdata1 = '0;
        tick(); tick();
        @(negedge clk);
        vectors++; if (bus.req_ready !== 2'b00) begin miscompares++; $display("FAIL rst_ready: got %b want 00", bus.req_ready); end
        vectors++; if (bus.rsp_valid !== 2'b00) begin miscompares++; $display("FAIL rst_rsp_valid: got %b want 00", bus.rsp_valid); end
        vectors++; if (bus.rsp_err !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_err: got %b want 0", bus.rsp_err); end
        vectors++; if (bus.rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_rdata: got %h want 0", bus.rsp_rdata); end
        vectors++; if ({bus.mem_en, bus.mem_we} !== 2'b00) begin miscompares++; $display("FAIL rst_mem_en_we: got %b want 00", {bus.mem_en, bus.mem_we}); end
        vectors++; if (bus.mem_addr !== 5'd0 || bus.mem_wdata !== 32'h0) begin miscompares++; $display("FAIL rst_mem_bus: got %h/%h want 0/0", bus.mem_addr, bus.mem_wdata); end
        vectors++; if (dut.r_state !== IDLE) begin miscompares++; $display("FAIL rst_state: got %0d want %0d", dut.r_state, IDLE); end
        $display("txn reset: 2 cycles held low");
        tick();
        bus.req_valid = 2'b00; mem_init = 1'b0; rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        bus.req_valid = 2'b01; bus.req_we = 2'b00; bus.req_addr0 = 32'd5;
        @(negedge clk);
        vectors++; if (bus.req_ready !== 2'b01) begin miscompares++; $display("FAIL rd_ready: got %b want 01", bus.req_ready); end
        tick();
        bus.req_valid = 2'b00; bus.req_addr0 = '0;
        @(negedge clk);
        vectors++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0) begin miscompares++; $display("FAIL rd_mem_en: got en=%b we=%b want 1/0", bus.mem_en, bus.mem_we); end
        vectors++; if (bus.mem_addr !== 5'd5) begin miscompares++; $display("FAIL rd_mem_addr: got %0d want 5", bus.mem_addr); end
        vectors++; if (bus.req_ready !== 2'b00) begin miscompares++; $display("FAIL rd_ready_access: got %b want 00", bus.req_ready); end
        tick();
        @(negedge clk);
        vectors++; if (bus.rsp_valid !== 2'b01) begin miscompares++; $display("FAIL rd_rsp_valid: got %b want 01", bus.rsp_valid); end
        vectors++; if (bus.rsp_rdata !== 32'hA5 || bus.rsp_err !== 1'b0) begin miscompares++; $display("FAIL rd_rdata: got %h err=%b want a5 err=0", bus.rsp_rdata, bus.rsp_err); end
        vectors++; if (bus.mem_en !== 1'b0) begin miscompares++; $display("FAIL rd_mem_en_resp: got %b want 0", bus.mem_en); end
        $display("txn single read: fetch addr 5 -> %h", bus.rsp_rdata);
        tick();
    endtask

    task automatic test_write_read();
        bus.req_valid = 2'b10; bus.req_we = 2'b10;
        bus.req_addr1 = 32'd31; bus.req_wdata1 = 32'hDEADBEEF;
        @(negedge clk);
        vectors++; if (bus.req_ready !== 2'b10) begin miscompares++; $display("FAIL wr_ready: got %b want 10", bus.req_ready); end
        tick();
        bus.req_valid = 2'b00;
        @(negedge clk);
        vectors++; if ({bus.mem_en, bus.mem_we} !== 2'b11 || bus.mem_addr !== 5'd31) begin miscompares++; $display("FAIL wr_mem: got en/we=%b addr=%0d want 11/31", {bus.mem_en, bus.mem_we}, bus.mem_addr); end
        vectors++; if (bus.mem_wdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL wr_wdata: got %h want deadbeef", bus.mem_wdata); end
        tick();
        @(negedge clk);
        vectors++; if (bus.rsp_valid !== 2'b10 || bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0) begin miscompares++; $display("FAIL wr_rsp: got v=%b d=%h e=%b want 10/0/0", bus.rsp_valid, bus.rsp_rdata, bus.rsp_err); end
        $display("txn write: lsu addr 31 <- deadbeef");
        tick();
        // Issued in the IDLE cycle right after RESP: must be accepted at once.
        bus.req_valid = 2'b10; bus.req_we = 2'b00;
        @(negedge clk);
        vectors++; if (bus.req_ready !== 2'b10) begin miscompares++; $display("FAIL rd2_ready: got %b want 10", bus.req_ready); end
        tick();
        bus.req_valid = 2'b00;
        @(negedge clk);
        vectors++; if ({bus.mem_en, bus.mem_we} !== 2'b10) begin miscompares++; $display("FAIL rd2_mem: got en/we=%b want 10", {bus.mem_en, bus.mem_we}); end
        tick();
        @(negedge clk);
        vectors++; if (bus.rsp_valid !== 2'b10 || bus.rsp_rdata !== 32'hDEADBEEF || bus.rsp_err !== 1'b0) begin miscompares++; $display("FAIL rd2_rsp: got v=%b d=%h e=%b want 10/deadbeef/0", bus.rsp_valid, bus.rsp_rdata, bus.rsp_err); end
        $display("txn read: lsu addr 31 -> %h", bus.rsp_rdata);
        tick();
    endtask

    task automatic test_contention();
        logic [1:0]  exp_gnt [4];
        logic [31:0] exp_data;
`ifdef MEM_ARB_RR_EN
        exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b10;
`else
        exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b01; exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b01;
`endif
        bus.req_valid = 2'b11; bus.req_we = 2'b00;
        bus.req_addr0 = 32'd2; bus.req_addr1 = 32'd3;
        for (int i = 0; i < 4; i++) begin
            exp_data = (exp_gnt[i] == 2'b01) ? 32'h22 : 32'h33;
            @(negedge clk);
            vectors++; if (bus.req_ready !== exp_gnt[i]) begin miscompares++; $display("FAIL cont_gnt%0d: got %b want %b", i, bus.req_ready, exp_gnt[i]); end
            tick();
            @(negedge clk);
            vectors++; if (bus.req_ready !== 2'b00) begin miscompares++; $display("FAIL cont_busy%0d: got %b want 00", i, bus.req_ready); end
            tick();
            @(negedge clk);
            vectors++; if (bus.rsp_valid !== exp_gnt[i] || bus.rsp_rdata !== exp_data) begin miscompares++; $display("FAIL cont_rsp%0d: got v=%b d=%h want %b/%h", i, bus.rsp_valid, bus.rsp_rdata, exp_gnt[i], exp_data); end
            $display("txn contention %0d: grant %b data %h", i, exp_gnt[i], bus.rsp_rdata);
            tick();
        end
        bus.req_valid = 2'b00;
    endtask

    task automatic test_out_of_range();
        logic [31:0] addrs [2];
        addrs[0] = 32'd32; addrs[1] = 32'h8000_0001;
        for (int i = 0; i < 2; i++) begin
            bus.req_valid = 2'b10; bus.req_we = (i == 1) ? 2'b10 : 2'b00;
            bus.req_addr1 = addrs[i]; bus.req_wdata1 = 32'h0000_0BAD;
            @(negedge clk);
            vectors++; if (bus.req_ready !== 2'b10) begin miscompares++; $display("FAIL oor_ready%0d: got %b want 10", i, bus.req_ready); end
            tick();
            bus.req_valid = 2'b00;
            @(negedge clk);
            vectors++; if (bus.mem_en !== 1'b0) begin miscompares++; $display("FAIL oor_mem_en%0d: got %b want 0", i, bus.mem_en); end
            tick();
            @(negedge clk);
            vectors++; if (bus.rsp_valid !== 2'b10 || bus.rsp_err !== 1'b1 || bus.rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL oor_rsp%0d: got v=%b e=%b d=%h want 10/1/0", i, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
            $display("txn out-of-range %0d: addr %h err %b", i, addrs[i], bus.rsp_err);
            tick();
        end
        vectors++; if (mem_model[1] !== 32'h11) begin miscompares++; $display("FAIL oor_alias: mem[1] got %h want 11", mem_model[1]); end
        bus.req_we = 2'b00;
    endtask

    task automatic test_reset_midop();
        bus.req_valid = 2'b10; bus.req_we = 2'b00; bus.req_addr1 = 32'd3;
        @(negedge clk);
        vectors++; if (bus.req_ready !== 2'b10) begin miscompares++; $display("FAIL mid_ready: got %b want 10", bus.req_ready); end
        tick();
        bus.req_valid = 2'b00; rst_n = 1'b0;
        @(negedge clk);
        vectors++; if (bus.rsp_valid !== 2'b00) begin miscompares++; $display("FAIL mid_rsp_a: got %b want 00", bus.rsp_valid); end
        tick();
        @(negedge clk);
        vectors++; if (bus.rsp_valid !== 2'b00 || dut.r_state !== IDLE) begin miscompares++; $display("FAIL mid_rsp_b: got v=%b st=%0d want 00/%0d", bus.rsp_valid, dut.r_state, IDLE); end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (bus.rsp_valid !== 2'b00) begin miscompares++; $display("FAIL mid_rsp_c: got %b want 00", bus.rsp_valid); end
        tick();
        bus.req_valid = 2'b11; bus.req_addr0 = 32'd2; bus.req_addr1 = 32'd3;
        @(negedge clk);
        vectors++; if (bus.req_ready !== 2'b01) begin miscompares++; $display("FAIL mid_regrant: got %b want 01", bus.req_ready); end
        tick();
        bus.req_valid = 2'b00;
        tick();
        @(negedge clk);
        vectors++; if (bus.rsp_valid !== 2'b01 || bus.rsp_rdata !== 32'h22) begin miscompares++; $display("FAIL mid_rsp_d: got v=%b d=%h want 01/22", bus.rsp_valid, bus.rsp_rdata); end
        $display("txn reset mid-op: regrant fetch data %h", bus.rsp_rdata);
        tick();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_single_read();
        test_write_read();
        test_contention();
        test_out_of_range();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
